flood_fill: RTL and testbench
=============================

# flood_fill

Flood-fill opener between the top-level game FSM and `board_cover`. On a single open request it reveals the selected cell; if that cell holds zero adjacent mines, it iteratively reveals every connected zero region plus its numbered border. It reads cell contents from `board` and `board_cover` through one coordinate port, and is the sole source of open strobes into `board_cover`. It returns the number of newly opened cells so the game FSM can decrement `cells_to_open`.

## Interface
- `X_SIZE`, 16, board width in cells
- `Y_SIZE`, 16, board height in cells
- `X_BITS`, 4, x coordinate width
- `Y_BITS`, 4, y coordinate width
- `clk`  in  1  system clock (`sys_clk`); one clock, all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle open request; ignored unless idle
- `start_x` / `start_y`  in  X_BITS / Y_BITS  cell to open
- `rd_x` / `rd_y`  out  X_BITS / Y_BITS  registered lookup coordinate to `board` and `board_cover`
- `rd_board_val`  in  5  combinational board value at `rd_x`/`rd_y`: 0–8 adjacency count, 5'b11111 mine
- `rd_cover_val`  in  2  combinational cover value: 00 covered, 01 opened, 1x flagged
- `open_req`  out  1  one-cycle strobe that opens (`open_x`, `open_y`) in `board_cover`
- `open_x` / `open_y`  out  X_BITS / Y_BITS  coordinate qualified by `open_req`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the fill completes
- `opened_count`  out  X_BITS+Y_BITS+1  cells opened by the last fill; valid from `done` until the next accepted `start`

## Operation
- State machine: IDLE, POP, READ, PUSH, DONE.
- IDLE: when `start`=1, clear the visited bitmap (X_SIZE·Y_SIZE bits, single cycle), clear `opened_count`, enqueue (`start_x`,`start_y`), mark it visited, and go to POP.
- POP: if the queue is empty, go to DONE. Otherwise dequeue, load the coordinate into `rd_x`/`rd_y`, and go to READ.
- READ: if `rd_cover_val`==00, pulse `open_req` with `open_x`/`open_y` = `rd_x`/`rd_y` and increment `opened_count`.
  - If that cell was opened and `rd_board_val`==0: go to PUSH with neighbour index 0.
  - Otherwise: go to POP.
  - Flagged and already-opened cells are never opened and never expanded.
  - A mine at the start cell is opened, so the top FSM detects the loss. It is not expanded.
- PUSH: evaluate one neighbour per cycle, in the order (-1,-1), (0,-1), (+1,-1), (-1,0), (+1,0), (-1,+1), (0,+1), (+1,+1).
  - Enqueue and mark visited only if the neighbour is in bounds (0 ≤ x < X_SIZE, 0 ≤ y < Y_SIZE) and not yet visited.
  - Bounds are checked in (X_BITS+1)-bit signed arithmetic; no wrap-around (x=15 → 0 is never generated).
  - After index 7, go to POP.
- DONE: assert `done` for one cycle, then go to IDLE.
- The visited bitmap guarantees at most X_SIZE·Y_SIZE enqueues, so the queue depth is X_SIZE·Y_SIZE and can never overflow.
- `start` while busy: ignored, with no effect on the current fill.
- Reset values (including reset mid-fill): state IDLE, queue empty, bitmap clear, and `busy`, `done`, `open_req`, `rd_x`, `rd_y`, `open_x`, `open_y`, `opened_count` all 0. No `open_req` is issued in the cycle after reset.

## Timing
- `start` sampled at cycle T:
  - POP at T+1.
  - READ at T+2, where `open_req` asserts if the cell is covered.
- Single non-zero cell: POP (empty) at T+3, `done` at T+4, `busy` low from T+5.
- Per expanded zero cell: 1 POP + 1 READ + 8 PUSH = 10 cycles. Per non-expanded cell: 2 cycles.
- `open_req` is never high in two consecutive cycles.
- `rd_board_val` and `rd_cover_val` must settle within the cycle after `rd_x`/`rd_y` update. No read latency is tolerated beyond that.

## Structure
- Shared `minesweeper_pkg` holds:
  - CELL_MINE = 5'b11111
  - cover codes COVER_HIDDEN = 2'b00, COVER_OPEN = 2'b01, COVER_FLAG bit = [1]
  - state encoding
  - the neighbour offset table
- Sub-module `coord_fifo`: synchronous FIFO, width X_BITS+Y_BITS, depth X_SIZE·Y_SIZE, with push, pop, empty and full flags. Same clk/reset.

## Test plan
- Covered cell (5,5) with value 3, start at T → exactly one `open_req` at (5,5) at T+2; `done` at T+4; `opened_count`=1.
- Flagged start cell (2,7) → no `open_req`; `done` at T+4; `opened_count`=0.
- All-covered, mine-free 16×16 board, start (8,8) → 256 `open_req`s, each coordinate exactly once; `opened_count`=256; no FIFO full assertion.
- (0,0)=0 with (1,0),(0,1),(1,1) valued 1, start (0,0) → opens in order (0,0), (1,0), (0,1), (1,1), then `done`. Repeated at (15,15): no coordinate outside 0–15 is emitted.
- Mine at (4,4), start (4,4) → one `open_req` at (4,4), no neighbours enqueued, `opened_count`=1.
- Second `start` during a fill → ignored. Reset asserted mid-fill → next cycle `busy`=0, `open_req`=0, `opened_count`=0; a fresh `start` then behaves as in the first scenario.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared minesweeper constants: cell/cover encodings, opener FSM states and
// the 8-neighbour offset table used by the flood-fill opener.
package minesweeper_pkg;

  localparam logic [4:0] CELL_MINE      = 5'b11111;
  localparam logic [1:0] COVER_HIDDEN   = 2'b00;
  localparam logic [1:0] COVER_OPEN     = 2'b01;
  localparam int         COVER_FLAG_BIT = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_READ = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } ff_state_t;

  // Neighbour order: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
  function automatic logic signed [1:0] nb_dx(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3, 3'd5: nb_dx = 2'sb11;
      3'd1, 3'd6:       nb_dx = 2'sb00;
      default:          nb_dx = 2'sb01;
    endcase
  endfunction

  function automatic logic signed [1:0] nb_dy(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: nb_dy = 2'sb11;
      3'd3, 3'd4:       nb_dy = 2'sb00;
      default:          nb_dy = 2'sb01;
    endcase
  endfunction

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO holding packed {y,x} cell coordinates for the flood fill.
// Read data is the head entry, available combinationally while not empty.
module coord_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flood_fill.sv
// Flood-fill opener: reveals the requested cell and, through a BFS queue and a
// visited bitmap, every connected zero region plus its numbered border.
module flood_fill
  import minesweeper_pkg::*;
#(
  parameter int X_SIZE = 16,
  parameter int Y_SIZE = 16,
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_BITS-1:0]        start_x,
  input  logic [Y_BITS-1:0]        start_y,
  output logic [X_BITS-1:0]        rd_x,
  output logic [Y_BITS-1:0]        rd_y,
  input  logic [4:0]               rd_board_val,
  input  logic [1:0]               rd_cover_val,
  output logic                     open_req,
  output logic [X_BITS-1:0]        open_x,
  output logic [Y_BITS-1:0]        open_y,
  output logic                     busy,
  output logic                     done,
  output logic [X_BITS+Y_BITS:0]   opened_count
);

  localparam int CELL_W = X_BITS + Y_BITS;
  localparam int CELLS  = X_SIZE * Y_SIZE;
  localparam logic [X_BITS:0] X_LIM = (X_BITS + 1)'(X_SIZE);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS + 1)'(Y_SIZE);

  ff_state_t          state;
  logic [2:0]         nb_idx;
  logic [CELLS-1:0]   visited;
  logic signed [1:0]  dx;
  logic signed [1:0]  dy;
  logic [X_BITS:0]    nx;
  logic [Y_BITS:0]    ny;
  logic               in_bounds;
  logic [CELL_W-1:0]  nb_cell;
  logic [CELL_W-1:0]  start_cell;
  logic               start_go;
  logic               nb_push;
  logic               fifo_push;
  logic               fifo_pop;
  logic [CELL_W-1:0]  fifo_din;
  logic [CELL_W-1:0]  fifo_dout;
  logic               fifo_empty;
  logic               fifo_full;

  assign dx = nb_dx(nb_idx);
  assign dy = nb_dy(nb_idx);
  // Values past the edge go negative or reach the size; the unsigned compare rejects both.
  assign nx = {1'b0, rd_x} + {{(X_BITS - 1){dx[1]}}, dx};
  assign ny = {1'b0, rd_y} + {{(Y_BITS - 1){dy[1]}}, dy};
  assign in_bounds = (nx < X_LIM) && (ny < Y_LIM);

  assign nb_cell    = CELL_W'(ny[Y_BITS-1:0]) * CELL_W'(X_SIZE) + CELL_W'(nx[X_BITS-1:0]);
  assign start_cell = CELL_W'(start_y) * CELL_W'(X_SIZE) + CELL_W'(start_x);

  assign start_go  = (state == S_IDLE) && start;
  assign nb_push   = (state == S_PUSH) && in_bounds && !visited[nb_cell] && !fifo_full;
  assign fifo_push = start_go || nb_push;
  assign fifo_pop  = (state == S_POP) && !fifo_empty;
  assign fifo_din  = start_go ? {start_y, start_x} : {ny[Y_BITS-1:0], nx[X_BITS-1:0]};

  assign open_req = (state == S_READ) && (rd_cover_val == COVER_HIDDEN);
  assign open_x   = rd_x;
  assign open_y   = rd_y;

  coord_fifo #(
    .WIDTH(CELL_W),
    .DEPTH(CELLS)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .din  (fifo_din),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Fill sequencer: dequeue, inspect, open, and expand zero cells one neighbour per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      nb_idx       <= 3'd0;
      visited      <= '0;
      rd_x         <= '0;
      rd_y         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      opened_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            visited             <= '0;
            visited[start_cell] <= 1'b1;
            opened_count        <= '0;
            busy                <= 1'b1;
            state               <= S_POP;
          end
        end
        S_POP: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            rd_x  <= fifo_dout[X_BITS-1:0];
            rd_y  <= fifo_dout[CELL_W-1:X_BITS];
            state <= S_READ;
          end
        end
        S_READ: begin
          if (open_req) begin
            opened_count <= opened_count + (CELL_W + 1)'(1);
          end
          nb_idx <= 3'd0;
          state  <= (open_req && rd_board_val == 5'd0) ? S_PUSH : S_POP;
        end
        S_PUSH: begin
          if (nb_push) begin
            visited[nb_cell] <= 1'b1;
          end
          nb_idx <= nb_idx + 3'd1;
          if (nb_idx == 3'd7) begin
            state <= S_POP;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flood_fill.sv
// Self-checking bench for flood_fill: a board/cover model answers lookups, a BFS
// reference model queues the expected open coordinates for the scoreboard.
module tb_flood_fill;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] start_x;
  logic [3:0] start_y;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [4:0] rd_board_val;
  logic [1:0] rd_cover_val;
  logic       open_req;
  logic [3:0] open_x;
  logic [3:0] open_y;
  logic       busy;
  logic       done;
  logic [8:0] opened_count;

  logic [4:0]  bv [16][16];
  logic [1:0]  init_cover [16][16];
  logic [15:0] opened_m [16];
  logic        clr_open = 1'b0;
  logic        prev_open = 1'b0;
  int          dup_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q [$];

  typedef struct {
    int sx;
    int sy;
    int scen;
    int exp_cnt;
    int exp_done;
  } vec_t;

  vec_t vecs [9];

  const int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  const int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  always #5 clk = ~clk;

  flood_fill dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_x     (start_x),
    .start_y     (start_y),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_board_val(rd_board_val),
    .rd_cover_val(rd_cover_val),
    .open_req    (open_req),
    .open_x      (open_x),
    .open_y      (open_y),
    .busy        (busy),
    .done        (done),
    .opened_count(opened_count)
  );

  assign rd_board_val = bv[rd_y][rd_x];
  assign rd_cover_val = opened_m[rd_y][rd_x] ? 2'b01 : init_cover[rd_y][rd_x];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // board_cover model: opened cells turn to COVER_OPEN
  always @(posedge clk) begin
    if (clr_open) begin
      for (int y = 0; y < 16; y++) opened_m[y] <= 16'h0000;
    end else if (open_req) begin
      if (opened_m[open_y][open_x]) dup_cnt <= dup_cnt + 1;
      opened_m[open_y][open_x] <= 1'b1;
    end
  end

  // scoreboard: every open strobe must match the next expected coordinate
  always @(negedge clk) begin
    if (open_req) begin
      check("open_gap", int'(prev_open), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL open_unexpected: got (%0d,%0d) expected none", open_x, open_y);
      end else begin
        check("open_xy", int'({open_y, open_x}), int'(exp_q.pop_front()));
      end
    end
    prev_open <= open_req;
  end

  task automatic setup(input int scen);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        case (scen)
          0, 1, 6: bv[y][x] = 5'd3;
          3, 4:    bv[y][x] = 5'd1;
          7:       bv[y][x] = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(8, 1));
          default: bv[y][x] = 5'd0;
        endcase
        init_cover[y][x] = (scen == 7 && $urandom_range(9) == 0) ? 2'b10 : 2'b00;
      end
    end
    case (scen)
      1: init_cover[7][2] = 2'b10;
      3: bv[0][0] = 5'd0;
      4: bv[15][15] = 5'd0;
      5: bv[4][4] = 5'b11111;
      6: init_cover[3][3] = 2'b01;
      default: ;
    endcase
    clr_open = 1'b1;
    @(negedge clk);
    clr_open = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_fill(input int sx, input int sy, output int cnt);
    bit vis [16][16];
    int q [$];
    int c, x, y, nx, ny;
    cnt = 0;
    q.push_back(sy * 16 + sx);
    vis[sy][sx] = 1'b1;
    while (q.size() > 0) begin
      c = q.pop_front();
      x = c % 16;
      y = c / 16;
      if (init_cover[y][x] == 2'b00) begin
        exp_q.push_back(8'(c));
        cnt++;
        if (bv[y][x] == 5'd0) begin
          for (int d = 0; d < 8; d++) begin
            nx = x + DX[d];
            ny = y + DY[d];
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[ny][nx]) begin
              vis[ny][nx] = 1'b1;
              q.push_back(ny * 16 + nx);
            end
          end
        end
      end
    end
  endtask

  // intr_k > 0 injects a second start at that cycle; stop_k > 0 applies reset at that cycle.
  task automatic run_vec(input vec_t v, input int intr_k, input int stop_k);
    int cnt_model, want_cnt, k;
    bit got_done;
    setup(v.scen);
    model_fill(v.sx, v.sy, cnt_model);
    want_cnt = (v.exp_cnt >= 0) ? v.exp_cnt : cnt_model;
    start_x = 4'(v.sx);
    start_y = 4'(v.sy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    got_done = 1'b0;
    while (k <= 4000) begin
      if (k == 2 && v.exp_done >= 0) check("open_at_T2", int'(open_req), int'(want_cnt > 0));
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (k == intr_k) begin
        start = 1'b1;
        start_x = 4'd9;
        start_y = 4'd9;
      end else begin
        start = 1'b0;
      end
      if (k == stop_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_open_req", int'(open_req), 0);
        check("rst_opened_count", int'(opened_count), 0);
        exp_q.delete();
        return;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!got_done) begin
      check("done_timeout", 0, 1);
    end else begin
      if (v.exp_done >= 0) check("done_cycle", k, v.exp_done);
      check("opened_count", int'(opened_count), want_cnt);
    end
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("pending_opens", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{5, 5, 0, 1, 4};
    vecs[1] = '{2, 7, 1, 0, 4};
    vecs[2] = '{8, 8, 2, 256, 2562};
    vecs[3] = '{0, 0, 3, 4, 18};
    vecs[4] = '{15, 15, 4, 4, 18};
    vecs[5] = '{4, 4, 5, 1, 4};
    vecs[6] = '{3, 3, 6, 0, 4};
    vecs[7] = '{6, 9, 7, -1, -1};
    vecs[8] = '{1, 12, 7, -1, -1};

    reset = 1'b1;
    start = 1'b0;
    start_x = 4'd0;
    start_y = 4'd0;
    setup(0);
    @(negedge clk);
    check("reset_outputs",
          int'({busy, done, open_req, rd_x, rd_y, open_x, open_y, opened_count}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], 0, 0);
    end
    check("no_duplicate_opens", dup_cnt, 0);

    // second start mid-fill must be ignored
    run_vec(vecs[3], 3, 0);
    // reset mid-fill, then a fresh single-cell open
    run_vec(vecs[2], 0, 40);
    @(negedge clk);
    run_vec(vecs[0], 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
